// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB pipeline bundle: the MEM_* op and stall in, the registered WB_* result out.
interface mem_wb_stage_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5
);
    logic              MEM_WRegEn;
    logic              MEM_WMemEn;
    logic [DATA_W-1:0] MEM_R1out;
    logic [DATA_W-1:0] MEM_R2out;
    logic [REG_W-1:0]  MEM_WReg1;
    logic              stall;
    logic              WB_WRegEn;
    logic [REG_W-1:0]  WB_WReg1;
    logic [DATA_W-1:0] WB_Data;
    logic              WB_AddrErr;

    modport master (
        output MEM_WRegEn, MEM_WMemEn, MEM_R1out, MEM_R2out, MEM_WReg1, stall,
        input  WB_WRegEn, WB_WReg1, WB_Data, WB_AddrErr
    );

    modport slave (
        input  MEM_WRegEn, MEM_WMemEn, MEM_R1out, MEM_R2out, MEM_WReg1, stall,
        output WB_WRegEn, WB_WReg1, WB_Data, WB_AddrErr
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage with word-addressed data memory and registered MEM/WB boundary.
// A host port preloads/inspects memory; pipeline stores always win the single write port.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    mem_wb_stage_if.slave     pipe,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [15:0]       store_cnt
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    logic              wb_wregen_q, wb_wregen_d;
    logic [REG_W-1:0]  wb_wreg1_q, wb_wreg1_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_aerr_q, wb_aerr_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [15:0]       store_cnt_q, store_cnt_d;

    logic [ADDR_W-1:0] idx;
    logic              aerr;
    logic              pipe_store;
    logic              host_commit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign idx  = pipe.MEM_R1out[ADDR_W-1:0];
    assign aerr = |pipe.MEM_R1out[DATA_W-1:ADDR_W];

    always_comb begin
        pipe_store  = ~pipe.stall & pipe.MEM_WMemEn & ~aerr;
        host_commit = host_we & ~pipe_store;
        // Reset suppresses every write, including a pending host write.
        wr_en       = ~reset & (pipe_store | host_commit);
        wr_idx      = pipe_store ? idx : host_addr;
        wr_data     = pipe_store ? pipe.MEM_R2out : host_wdata;

        wb_wregen_d  = wb_wregen_q;
        wb_wreg1_d   = wb_wreg1_q;
        wb_data_d    = wb_data_q;
        wb_aerr_d    = wb_aerr_q;
        store_cnt_d  = store_cnt_q;
        host_ack_d   = host_commit;
        host_rdata_d = mem_q[host_addr];

        if (!pipe.stall) begin
            wb_wregen_d = pipe.MEM_WRegEn & ~aerr;
            wb_wreg1_d  = pipe.MEM_WReg1;
            wb_data_d   = aerr ? '0 : mem_q[idx];
            wb_aerr_d   = aerr & (pipe.MEM_WRegEn | pipe.MEM_WMemEn);
        end
        if (pipe_store && store_cnt_q != 16'hFFFF) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_wregen_q  <= 1'b0;
            wb_wreg1_q   <= '0;
            wb_data_q    <= '0;
            wb_aerr_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            store_cnt_q  <= '0;
        end else begin
            wb_wregen_q  <= wb_wregen_d;
            wb_wreg1_q   <= wb_wreg1_d;
            wb_data_q    <= wb_data_d;
            wb_aerr_q    <= wb_aerr_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    // Memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign pipe.WB_WRegEn  = wb_wregen_q;
    assign pipe.WB_WReg1   = wb_wreg1_q;
    assign pipe.WB_Data    = wb_data_q;
    assign pipe.WB_AddrErr = wb_aerr_q;
    assign host_ack        = host_ack_q;
    assign host_rdata      = host_rdata_q;
    assign store_cnt       = store_cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage plus hand sequences for stall, saturation, reset.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [63:0] host_wdata;
    logic        host_ack;
    logic [63:0] host_rdata;
    logic [15:0] store_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage_if #(.DATA_W(64), .REG_W(5)) pipe ();

    mem_wb_stage #(.DATA_W(64), .ADDR_W(8), .REG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe       (pipe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .store_cnt  (store_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, wregen, wmemen;
        logic [63:0] r1, r2;
        logic [4:0]  wreg1;
        logic        hwe;
        logic [7:0]  haddr;
        logic [63:0] hwdata;
        logic        e_wregen;
        logic [4:0]  e_wreg1;
        logic        chk_data;
        logic [63:0] e_data;
        logic        e_aerr, e_ack, chk_rdata;
        logic [63:0] e_rdata;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic st, logic wr, logic wm, logic [63:0] r1, logic [63:0] r2,
                                logic [4:0] wreg, logic hwe, logic [7:0] ha, logic [63:0] hd,
                                logic e_wr, logic [4:0] e_wreg, logic cd, logic [63:0] ed,
                                logic e_ae, logic e_ack, logic cr, logic [63:0] er,
                                logic [15:0] ec);
        vec_t v;
        v.stall = st; v.wregen = wr; v.wmemen = wm; v.r1 = r1; v.r2 = r2; v.wreg1 = wreg;
        v.hwe = hwe; v.haddr = ha; v.hwdata = hd;
        v.e_wregen = e_wr; v.e_wreg1 = e_wreg; v.chk_data = cd; v.e_data = ed;
        v.e_aerr = e_ae; v.e_ack = e_ack; v.chk_rdata = cr; v.e_rdata = er; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_pipe(input logic st, input logic wr, input logic wm, input logic [63:0] r1,
                            input logic [63:0] r2, input logic [4:0] wreg);
        pipe.stall = st; pipe.MEM_WRegEn = wr; pipe.MEM_WMemEn = wm;
        pipe.MEM_R1out = r1; pipe.MEM_R2out = r2; pipe.MEM_WReg1 = wreg;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic wr, input logic [4:0] wreg,
                          input logic [63:0] d, input logic ae, input logic [15:0] cnt);
        chk({tag, " WB_WRegEn"}, {63'd0, pipe.WB_WRegEn}, {63'd0, wr});
        chk({tag, " WB_WReg1"}, {59'd0, pipe.WB_WReg1}, {59'd0, wreg});
        chk({tag, " WB_Data"}, pipe.WB_Data, d);
        chk({tag, " WB_AddrErr"}, {63'd0, pipe.WB_AddrErr}, {63'd0, ae});
        chk({tag, " store_cnt"}, {48'd0, store_cnt}, {48'd0, cnt});
    endtask

    vec_t vecs[14];

    initial begin
        // st wr wm r1 r2 wreg | hwe ha hd | e_wr e_wreg cd ed | ae ack cr er | cnt
        vecs[0]  = mk(0,0,0,64'h0,64'h0,0, 1,8'd0,64'hAAAA, 0,0,0,64'h0, 0,1,0,64'h0, 16'd0);
        vecs[1]  = mk(0,0,0,64'h0,64'h0,0, 1,8'd7,64'h11, 0,0,1,64'hAAAA, 0,1,0,64'h0, 16'd0);
        vecs[2]  = mk(0,0,0,64'h0,64'h0,0, 1,8'd9,64'h09, 0,0,1,64'hAAAA, 0,1,0,64'h0, 16'd0);
        vecs[3]  = mk(0,0,1,64'd5,64'hDEAD_BEEF,0, 0,8'd0,64'h0,
                      0,0,0,64'h0, 0,0,1,64'hAAAA, 16'd1);
        vecs[4]  = mk(0,1,0,64'd5,64'h0,3, 0,8'd0,64'h0,
                      1,3,1,64'hDEAD_BEEF, 0,0,1,64'hAAAA, 16'd1);
        vecs[5]  = mk(0,1,0,64'h100,64'h0,4, 0,8'd0,64'h0, 0,4,1,64'h0, 1,0,1,64'hAAAA, 16'd1);
        vecs[6]  = mk(0,0,1,64'h100,64'h55,0, 0,8'd0,64'h0, 0,0,1,64'h0, 1,0,1,64'hAAAA, 16'd1);
        vecs[7]  = mk(0,1,0,64'h0,64'h0,1, 0,8'd0,64'h0, 1,1,1,64'hAAAA, 0,0,1,64'hAAAA, 16'd1);
        vecs[8]  = mk(0,1,1,64'd7,64'h22,2, 0,8'd7,64'h0, 1,2,1,64'h11, 0,0,1,64'h11, 16'd2);
        vecs[9]  = mk(0,1,0,64'd7,64'h0,2, 0,8'd7,64'h0, 1,2,1,64'h22, 0,0,1,64'h22, 16'd2);
        // Host write collides with a pipeline store and is dropped.
        vecs[10] = mk(0,0,1,64'd10,64'h1010,0, 1,8'd9,64'h99, 0,0,0,64'h0, 0,0,1,64'h09, 16'd3);
        // Retry under stall commits; rdata still shows the old word (read-before-write).
        vecs[11] = mk(1,1,1,64'd5,64'hBAD,7, 1,8'd9,64'h99, 0,0,0,64'h0, 0,1,1,64'h09, 16'd3);
        vecs[12] = mk(0,1,0,64'd10,64'h0,6, 0,8'd9,64'h0, 1,6,1,64'h1010, 0,0,1,64'h99, 16'd3);
        vecs[13] = mk(0,1,0,64'd5,64'h0,8, 0,8'd9,64'h0,
                      1,8,1,64'hDEAD_BEEF, 0,0,1,64'h99, 16'd3);

        // Reset with a pending load-enable.
        reset = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        set_pipe(0, 1, 0, 64'd3, 64'h0, 5'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_wb("reset", 0, 0, 64'h0, 0, 16'd0);
            chk("reset host_ack", {63'd0, host_ack}, 64'd0);
            chk("reset host_rdata", host_rdata, 64'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_pipe(vecs[i].stall, vecs[i].wregen, vecs[i].wmemen, vecs[i].r1, vecs[i].r2,
                     vecs[i].wreg1);
            host_we = vecs[i].hwe; host_addr = vecs[i].haddr; host_wdata = vecs[i].hwdata;
            tick();
            chk($sformatf("v%0d WB_WRegEn", i), {63'd0, pipe.WB_WRegEn},
                {63'd0, vecs[i].e_wregen});
            chk($sformatf("v%0d WB_WReg1", i), {59'd0, pipe.WB_WReg1}, {59'd0, vecs[i].e_wreg1});
            if (vecs[i].chk_data) chk($sformatf("v%0d WB_Data", i), pipe.WB_Data, vecs[i].e_data);
            chk($sformatf("v%0d WB_AddrErr", i), {63'd0, pipe.WB_AddrErr},
                {63'd0, vecs[i].e_aerr});
            chk($sformatf("v%0d host_ack", i), {63'd0, host_ack}, {63'd0, vecs[i].e_ack});
            if (vecs[i].chk_rdata) chk($sformatf("v%0d host_rdata", i), host_rdata,
                                       vecs[i].e_rdata);
            chk($sformatf("v%0d store_cnt", i), {48'd0, store_cnt}, {48'd0, vecs[i].e_cnt});
        end

        // Three stalled cycles with changing MEM_*: everything holds.
        set_pipe(1, 1, 1, 64'd5, 64'h1, 5'd9);   tick(); chk_wb("stall0", 1, 8, 64'hDEAD_BEEF, 0, 3);
        set_pipe(1, 1, 0, 64'h200, 64'h2, 5'd10); tick(); chk_wb("stall1", 1, 8, 64'hDEAD_BEEF, 0, 3);
        set_pipe(1, 0, 1, 64'd20, 64'h3, 5'd11); tick(); chk_wb("stall2", 1, 8, 64'hDEAD_BEEF, 0, 3);

        // Drive the store counter to saturation.
        set_pipe(0, 0, 1, 64'd20, 64'h5, 5'd0);
        for (int i = 0; i < 65532; i++) tick();
        chk("sat reach", {48'd0, store_cnt}, 64'hFFFF);
        tick();
        chk("sat hold", {48'd0, store_cnt}, 64'hFFFF);

        // Reset mid-stall with a pipeline store and host write pending: nothing written.
        set_pipe(1, 1, 1, 64'd5, 64'hBAD0, 5'd4); tick();
        reset = 1'b1; set_pipe(1, 1, 1, 64'd5, 64'hBAD0, 5'd4);
        host_we = 1'b1; host_addr = 8'd9; host_wdata = 64'h77;
        tick();
        chk_wb("rst_mid", 0, 0, 64'h0, 0, 16'd0);
        chk("rst_mid host_ack", {63'd0, host_ack}, 64'd0);
        chk("rst_mid host_rdata", host_rdata, 64'd0);
        reset = 1'b0; host_we = 1'b0;
        set_pipe(0, 1, 0, 64'd5, 64'h0, 5'd1);
        tick();
        chk("post_rst host_rdata", host_rdata, 64'h99);
        chk("post_rst WB_Data", pipe.WB_Data, 64'hDEAD_BEEF);
        chk("post_rst store_cnt", {48'd0, store_cnt}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
